// File: rtl/quantum_pkg.sv
// quantum_pkg: shared constants and FSM state type for the quantum register bank arbiter
package quantum_pkg;
  localparam int QR_DW = 16;
  localparam logic [QR_DW-1:0] QR_RW_BASE = 16'h0000;
  localparam logic [QR_DW-1:0] QR_RO_BASE = 16'h0020;
  localparam logic [QR_DW-1:0] QR_END = 16'h0040;
  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, DONE} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above i_ptr with wrap
module rr_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) o_idx = IW'((int'(i_ptr) + k) % N);
    o_any = |i_req;
    o_gnt = o_any ? (N'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/quantum_arb.sv
// quantum_arb: round-robin arbiter sharing the quantum register bank's two-cycle bus port
module quantum_arb
  import quantum_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      we,
  input  logic [N*16-1:0]   addr,
  input  logic [N*16-1:0]   wdata,
  output logic [N-1:0]      ack,
  output logic              err,
  output logic [QR_DW-1:0] rdata,
  output logic              m_hsel,
  output logic              m_hwrite,
  output logic [31:0]       m_haddr,
  output logic [31:0]       m_hwdata,
  input  logic [31:0]       m_hrdata
);
  localparam int IW = $clog2(N);
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, w_idx, w_ptr_next;
  logic [N-1:0] r_win_oh, w_req, w_gnt;
  logic r_we, r_err, w_any, w_go, w_unused;
  logic [QR_DW-1:0] r_addr, r_wdata, r_rdata;

  // The winner's req is still high during DONE, so mask it out of the re-arbitration.
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  always_comb begin
    w_req = (r_state == DONE) ? (req & ~r_win_oh) : req;
    w_go = ((r_state == IDLE) || (r_state == DONE)) && w_any;
    w_ptr_next = (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
    w_next = (r_state == ISSUE) ? COMMIT : (r_state == COMMIT) ? DONE : w_go ? ISSUE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_win_oh <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_ptr <= w_ptr_next;
        r_win_oh <= w_gnt;
        r_we <= we[w_idx];
        r_addr <= addr[16*w_idx +: 16];
        r_wdata <= wdata[16*w_idx +: 16];
      end
      if (r_state == COMMIT) begin
        r_rdata <= m_hrdata[QR_DW-1:0];
        r_err <= (r_addr >= QR_END) || (r_we && (r_addr >= QR_RO_BASE));
      end
    end
  end

  assign w_unused = ^m_hrdata[31:16];
  assign ack = (r_state == DONE) ? r_win_oh : '0;
  assign err = (r_state == DONE) && r_err;
  assign rdata = r_rdata;
  assign m_hsel = (r_state == ISSUE);
  assign m_hwrite = (r_state == ISSUE) && r_we;
  assign m_haddr = {16'h0000, r_addr[15:2], 2'b00};
  assign m_hwdata = {16'h0000, r_wdata};
endmodule

// File: tb/tb_quantum_arb.sv
// tb_quantum_arb: directed checks of quantum_arb (N=2 against a bank model, N=4 for pointer order)
module tb_quantum_arb;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, we, ack;
  logic [31:0] addr, wdata, m_haddr, m_hwdata, m_hrdata;
  logic err, m_hsel, m_hwrite;
  logic [15:0] rdata;
  logic [3:0] req4, ack4;
  logic err4, hsel4, hwrite4;
  logic [15:0] rdata4;
  logic [31:0] haddr4, hwdata4;
  logic [15:0] mem [8] = '{default: 16'h0};
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  quantum_arb #(.N(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .m_hsel(m_hsel), .m_hwrite(m_hwrite),
    .m_haddr(m_haddr), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata)
  );

  quantum_arb #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(4'b0000), .addr(64'h0), .wdata(64'h0),
    .ack(ack4), .err(err4), .rdata(rdata4), .m_hsel(hsel4), .m_hwrite(hwrite4),
    .m_haddr(haddr4), .m_hwdata(hwdata4), .m_hrdata(32'h0)
  );

  // Bank model: RW regs at 0x00-0x1F (stride 4), RO regs return 0xA000|index, 0 beyond 0x40.
  always_comb
    m_hrdata = (m_haddr < 32'h20) ? {16'h0, mem[m_haddr[4:2]]} :
               (m_haddr < 32'h40) ? {16'h0, 13'h1400, m_haddr[4:2]} : 32'h0;

  always @(posedge clk)
    if (m_hsel && m_hwrite && m_haddr < 32'h20) mem[m_haddr[4:2]] <= m_hwdata[15:0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; req4 = '0;
    tick; tick;
    chk("reset_ctl", {28'h0, ack, err, m_hsel, m_hwrite}, 32'h0);
    chk("reset_haddr", m_haddr, 32'h0);
    chk("reset_hwdata", m_hwdata, 32'h0);
    chk("reset_rdata", {16'h0, rdata}, 32'h0);
    rst = 1'b0;
    req = 2'b01; we = 2'b01; addr = 32'h0000_0008; wdata = 32'h0000_BEEF;
    chk("wr_c0_hsel", {31'h0, m_hsel}, 32'h0);
    tick;
    chk("wr_c1_ctl", {28'h0, ack, m_hsel, m_hwrite}, 32'h3);
    chk("wr_c1_haddr", m_haddr, 32'h8);
    chk("wr_c1_hwdata", m_hwdata, 32'h0000_BEEF);
    tick;
    chk("wr_c2_ctl", {28'h0, ack, m_hsel, m_hwrite}, 32'h0);
    chk("wr_c2_haddr", m_haddr, 32'h8);
    tick;
    chk("wr_c3_ack", {29'h0, ack, err}, 32'h2);
    chk("wr_c3_hsel", {31'h0, m_hsel}, 32'h0);
    req = 2'b00;
    tick;
    chk("wr_idle_ack", {30'h0, ack}, 32'h0);
    chk("wr_bank", {16'h0, mem[2]}, 32'h0000_BEEF);
    req = 2'b10; we = 2'b00; addr = 32'h0008_0000;
    tick; tick; tick;
    chk("rd_ack", {29'h0, ack, err}, 32'h4);
    chk("rd_rdata", {16'h0, rdata}, 32'h0000_BEEF);
    req = 2'b00;
    tick;
    chk("rd_hold", {14'h0, ack, rdata}, 32'h0000_BEEF);
    req = 2'b01; we = 2'b01; addr = 32'h0000_0024; wdata = 32'h0000_1234;
    tick;
    chk("ewr_issued", {30'h0, m_hsel, m_hwrite}, 32'h3);
    tick; tick;
    chk("ewr_ack_err", {29'h0, ack, err}, 32'h3);
    req = 2'b00;
    tick;
    req = 2'b10; we = 2'b00; addr = 32'h0024_0000;
    tick; tick; tick;
    chk("ro_read_ack", {29'h0, ack, err}, 32'h4);
    chk("ro_unchanged", {16'h0, rdata}, 32'h0000_A001);
    req = 2'b00;
    tick;
    req = 2'b01; addr = 32'h0000_0040;
    tick; tick; tick;
    chk("oob_read_err", {29'h0, ack, err}, 32'h3);
    chk("oob_rdata", {16'h0, rdata}, 32'h0);
    req = 2'b00;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 2'b11; we = 2'b00; addr = 32'h0028_0008;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("cont_hsel_on", {31'h0, m_hsel}, 32'h1);
      tick;
      chk("cont_mid", {29'h0, ack, m_hsel}, 32'h0);
      tick;
      chk("cont_ack", {29'h0, ack, m_hsel}, (k % 2 == 0) ? 32'h2 : 32'h4);
      chk("cont_rdata", {16'h0, rdata}, (k % 2 == 0) ? 32'h0000_BEEF : 32'h0000_A002);
    end
    req = 2'b00;
    tick;
    req = 2'b01;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_commit", {29'h0, ack, m_hsel}, 32'h0);
    req = 2'b11;
    tick; tick; tick;
    chk("post_rst_first", {30'h0, ack}, 32'h1);
    tick; tick; tick;
    chk("post_rst_second", {30'h0, ack}, 32'h2);
    req = 2'b00;
    tick;
    req4 = 4'b0010;
    tick; tick; tick;
    chk("n4_setup", {28'h0, ack4}, 32'h2);
    req4 = 4'b0000;
    tick;
    req4 = 4'b1010;
    tick; tick; tick;
    chk("n4_first", {28'h0, ack4}, 32'h8);
    req4 = 4'b0010;
    tick; tick; tick;
    chk("n4_second", {28'h0, ack4}, 32'h2);
    req4 = 4'b0000;
    tick;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
